// File: rtl/imem_pkg.sv
// Shared types and constants for the I-cache miss-port memory responder.
package imem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Fibonacci taps 8,6,5,4 expressed as a bit mask over lfsr[7:0]
  localparam logic [7:0] LFSR_TAPS   = 8'hB8;
  localparam int         MAX_LATENCY = 15;
  // Wide enough for MAX_LATENCY-1 plus up to 3 jitter cycles
  localparam int         CNT_W       = 6;
endpackage

// File: rtl/imem_wait_timer.sv
// Wait-state down-counter; loads LATENCY-1 (plus 0..3 LFSR jitter when IMEM_JITTER_EN is defined).
// No latency of its own: zero reflects the registered count; load wins over dec.
module imem_wait_timer
  import imem_pkg::*;
#(
  parameter int         LATENCY   = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic clk,
  input  logic clrn,
  input  logic load,
  input  logic accept,
  input  logic dec,
  output logic zero
);
  localparam int LAT_C = (LATENCY > MAX_LATENCY) ? MAX_LATENCY :
                         ((LATENCY < 1) ? 1 : LATENCY);
  localparam logic [CNT_W-1:0] BASE = CNT_W'(LAT_C - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

`ifdef IMEM_JITTER_EN
  logic [7:0] lfsr;
  logic [1:0] jit;
  logic [1:0] jit_sel;

  // A fresh accept takes the current LFSR bits; a restart reuses the last one
  assign jit_sel  = accept ? lfsr[1:0] : jit;
  assign load_val = BASE + {{(CNT_W-2){1'b0}}, jit_sel};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lfsr <= LFSR_SEED;
      jit  <= 2'd0;
    end else if (accept) begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
      jit  <= lfsr[1:0];
    end
  end
`else
  logic unused_jitter;
  assign unused_jitter = accept ^ (^LFSR_SEED);
  assign load_val      = BASE;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/imem_responder.sv
// I-cache miss responder: one word read at a time, m_ready LATENCY edges after accept (IMEM_JITTER_EN adds 0..3).
// The cache holds m_strobe until served; dropping it in WAIT abandons, changing m_a restarts the wait.
module imem_responder
  import imem_pkg::*;
#(
  parameter int         A_WIDTH   = 32,
  parameter int         M_INDEX   = 12,
  parameter int         LATENCY   = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH:0]   m_a,
  input  logic               m_strobe,
  output logic               m_ready,
  output logic [31:0]        m_dout,
  output logic               bus_err,
  output logic               busy,
  input  logic               ld_we,
  input  logic [M_INDEX-1:0] ld_addr,
  input  logic [31:0]        ld_data
);
  localparam int RW    = A_WIDTH - 1;
  localparam int DEPTH = 1 << M_INDEX;

  state_t          state, state_n;
  logic [RW-1:0]   req, req_n, cur;
  logic            ready_n, err_n, busy_n;
  logic [31:0]     dout_n;
  logic            load, accept, dec, zero, oor;
  logic [31:0]     mem [DEPTH];
  logic            unused_lo;

  // Byte-offset bits never take part in matching or decode
  assign unused_lo = ^m_a[1:0];
  assign cur       = m_a[A_WIDTH:2];
  assign oor       = |req[RW-1:M_INDEX];

  imem_wait_timer #(
    .LATENCY   (LATENCY),
    .LFSR_SEED (LFSR_SEED)
  ) u_timer (
    .clk    (clk),
    .clrn   (clrn),
    .load   (load),
    .accept (accept),
    .dec    (dec),
    .zero   (zero)
  );

  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
  end

  always_comb begin
    state_n = state;
    req_n   = req;
    ready_n = 1'b0;
    err_n   = 1'b0;
    dout_n  = m_dout;
    load    = 1'b0;
    accept  = 1'b0;
    dec     = 1'b0;
    case (state)
      IDLE: begin
        if (m_strobe) begin
          req_n   = cur;
          load    = 1'b1;
          accept  = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (!m_strobe) begin
          state_n = IDLE;
        end else if (cur != req) begin
          req_n = cur;
          load  = 1'b1;
        end else if (!zero) begin
          dec = 1'b1;
        end else begin
          // Array read samples the pre-edge word, so a same-edge load is not seen
          ready_n = 1'b1;
          state_n = RESP;
          if (oor) begin
            dout_n = 32'h0000_0000;
            err_n  = 1'b1;
          end else begin
            dout_n = mem[req[M_INDEX-1:0]];
          end
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      req     <= '0;
      m_ready <= 1'b0;
      m_dout  <= 32'h0000_0000;
      bus_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      req     <= req_n;
      m_ready <= ready_n;
      m_dout  <= dout_n;
      bus_err <= err_n;
      busy    <= busy_n;
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Randomized scoreboard bench for imem_responder: driver queues expected responses, negedge monitor checks them.
module tb_imem_responder;
  localparam int L  = 2;
  localparam int AW = 32;
  localparam int MI = 12;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic [AW:0]   m_a = '0;
  logic          m_strobe = 1'b0;
  logic          ld_we = 1'b0;
  logic [MI-1:0] ld_addr = '0;
  logic [31:0]   ld_data = '0;
  logic          m_ready, bus_err, busy;
  logic [31:0]   m_dout;

  imem_responder #(.A_WIDTH(AW), .M_INDEX(MI), .LATENCY(L), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .clrn(clrn), .m_a(m_a), .m_strobe(m_strobe),
    .m_ready(m_ready), .m_dout(m_dout), .bus_err(bus_err), .busy(busy),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl[int];
  int          wr_idx[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_dout = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the head of the scoreboard, including its cycle
  exp_t ent;
  always @(negedge clk) begin
    if (!clrn) begin
      exp_dout = 32'h0;
    end else if (m_ready) begin
      if (q.size() == 0) begin
        check("spurious_ready", 64'(m_ready), 64'd0);
      end else begin
        ent = q.pop_front();
        check("rsp_data", 64'(m_dout), 64'(ent.d));
        check("rsp_err", 64'(bus_err), 64'(ent.e));
        check("rsp_cycle", 64'(cyc), 64'(ent.c));
        exp_dout = ent.d;
      end
    end else begin
      check("dout_hold", 64'(m_dout), 64'(exp_dout));
      check("err_idle", 64'(bus_err), 64'd0);
    end
  end

  task automatic load(input int idx, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = idx[MI-1:0];
    ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
    if (!mdl.exists(idx)) wr_idx.push_back(idx);
    mdl[idx] = d;
  endtask

  // Raise (or retarget) the strobe; when push is set the response is expected L edges after the next edge
  task automatic issue(input logic [AW:0] addr, input bit push);
    exp_t e;
    int   idx;
    m_strobe = 1'b1;
    m_a      = addr;
    if (push) begin
      idx = int'(addr[MI+1:2]);
      e.e = |addr[AW:MI+2];
      if (e.e) e.d = 32'h0;
      else     e.d = mdl[idx];
      e.c = cyc + 1 + L;
      q.push_back(e);
    end
  endtask

  task automatic complete(input bit col, input int cidx, input logic [31:0] cdata);
    for (int i = 0; i <= L; i++) begin
      @(negedge clk);
      check("busy_wait", 64'(busy), 64'd1);
      if (col && i == L - 1) begin
        ld_we   = 1'b1;
        ld_addr = cidx[MI-1:0];
        ld_data = cdata;
      end
      if (col && i == L) begin
        ld_we = 1'b0;
        mdl[cidx] = cdata;
      end
    end
    m_strobe = 1'b0;
    @(negedge clk);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  function automatic logic [AW:0] rand_addr(input bit bad);
    logic [AW:0] a;
    int          idx;
    idx = wr_idx[$urandom_range(0, wr_idx.size() - 1)];
    a   = (33'(idx) << 2) | 33'($urandom_range(0, 3));
    if (bad) a = a | (33'h1 << $urandom_range(MI + 2, AW));
    return a;
  endfunction

  initial begin
    logic [AW:0] a1, a2;
    int          k;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(m_ready), 64'd0);
    check("rst_dout", 64'(m_dout), 64'd0);
    check("rst_err", 64'(bus_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    clrn = 1'b1;
    @(negedge clk);

    load(5, 32'hDEAD_BEEF);
    load(8, 32'h1234_5678);
    for (int i = 0; i < 14; i++) load(int'($urandom_range(0, (1 << MI) - 1)), $urandom);

    // Plain read of index 5
    issue(33'h14, 1'b1);
    complete(1'b0, 0, 32'h0);

    // Abandon after one edge, then a full-latency read
    issue(33'h14, 1'b0);
    @(negedge clk);
    m_strobe = 1'b0;
    @(negedge clk);
    check("abandon_busy", 64'(busy), 64'd0);
    issue(33'h14, 1'b1);
    complete(1'b0, 0, 32'h0);

    // Redirect mid-wait from 0x14 to 0x20
    issue(33'h14, 1'b0);
    @(negedge clk);
    issue(33'h20, 1'b1);
    complete(1'b0, 0, 32'h0);

    // Out-of-range address
    issue(33'h1_0000_0000, 1'b1);
    complete(1'b0, 0, 32'h0);

    // Load to the same index on the response edge, then re-read
    issue(33'h14, 1'b1);
    complete(1'b1, 5, 32'hCAFE_0001);
    issue(33'h14, 1'b1);
    complete(1'b0, 0, 32'h0);

    // Reset mid-wait: outputs clear at once, array survives
    issue(33'h20, 1'b0);
    @(negedge clk);
    clrn     = 1'b0;
    m_strobe = 1'b0;
    exp_dout = 32'h0;
    #1;
    check("arst_ready", 64'(m_ready), 64'd0);
    check("arst_dout", 64'(m_dout), 64'd0);
    check("arst_err", 64'(bus_err), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    issue(33'h14, 1'b1);
    complete(1'b0, 0, 32'h0);
    issue(33'h20, 1'b1);
    complete(1'b0, 0, 32'h0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          k = int'($urandom_range(1, L));
          issue(rand_addr(1'b0), 1'b0);
          repeat (k) @(negedge clk);
          m_strobe = 1'b0;
          @(negedge clk);
          check("rnd_abandon_busy", 64'(busy), 64'd0);
        end
        2: begin
          issue(rand_addr(1'b1), 1'b1);
          complete(1'b0, 0, 32'h0);
        end
        3: load(int'($urandom_range(0, (1 << MI) - 1)), $urandom);
        4: begin
          a1 = rand_addr(1'b0);
          a2 = rand_addr(1'b0);
          if (a2[AW:2] == a1[AW:2]) a2 = rand_addr(1'b1);
          issue(a1, 1'b0);
          @(negedge clk);
          issue(a2, 1'b1);
          complete(1'b0, 0, 32'h0);
        end
        default: begin
          issue(rand_addr(1'b0), 1'b1);
          complete(1'b0, 0, 32'h0);
        end
      endcase
    end

    repeat (4) @(negedge clk);
    check("queue_drain", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Memory-side responder for the instruction-cache miss interface (m_a / m_strobe / m_ready / m_dout). It accepts one word-read request at a time and returns the word after a programmable number of wait states. Data comes from an on-chip word array, pre-loadable through a side load port. It sits between the I-cache and the boot/test memory image, and lets cache miss and flush behaviour be exercised with realistic latency.

Parameters:
A_WIDTH, 32, cache address width; request address port is A_WIDTH+1 bits
M_INDEX, 12, log2 of array depth in 32-bit words (default 4096 words)
LATENCY, 2, wait cycles before response; legal range 1..15
LFSR_SEED, 8'hA5, nonzero seed for the jitter LFSR (used only with the optional feature)

Ports:
clk  in  1  clock
clrn  in  1  reset, asynchronous, active-low
m_a  in  A_WIDTH+1  request byte address; bits [1:0] ignored
m_strobe  in  1  read request, held high by the cache until served or abandoned
m_ready  out  1  one-cycle pulse: m_dout valid for current request
m_dout  out  32  read data, registered
bus_err  out  1  pulses with m_ready when the address is out of range
busy  out  1  high in WAIT or RESP
ld_we  in  1  load-port write enable
ld_addr  in  M_INDEX  load-port word index
ld_data  in  32  load-port write data

Behaviour:
- Reset (clrn low, asynchronous): state IDLE; m_ready=0, m_dout=0, bus_err=0, busy=0, counter=0, LFSR=LFSR_SEED. Array contents are not cleared.
- Reset during WAIT or RESP aborts the request. No m_ready is produced.
- States: IDLE, WAIT, RESP. All outputs are registered.
- IDLE: at an edge with m_strobe=1, latch m_a into req_a, load cnt=LATENCY-1, go to WAIT.
- WAIT, m_strobe=0 at edge: abandon, go to IDLE, no m_ready.
- WAIT, m_strobe=1 and m_a!=req_a (PC redirect after flush): relatch req_a, reload cnt=LATENCY-1, stay in WAIT.
- WAIT, m_strobe=1, address unchanged, cnt!=0: decrement cnt.
- WAIT, m_strobe=1, address unchanged, cnt==0: set m_ready=1, load m_dout, go to RESP.
- RESP: m_ready=0 and bus_err=0 at the next edge, go to IDLE unconditionally. A strobe still high during RESP is not accepted; earliest new accept is the edge after RESP.
- Latency: the strobe is first sampled at edge E0, so m_ready is high for exactly the cycle after edge E0+LATENCY+1-1 = E0+LATENCY, i.e. LATENCY+1 edges after the request is raised (E0 counts as one). m_dout holds its value until the next response.
- Address decode: word index = req_a[M_INDEX+1:2].
- Out of range: if any bit of req_a[A_WIDTH:M_INDEX+2] is set, m_dout=32'h0000_0000 and bus_err=1 alongside m_ready.
- Load port: ld_we writes array[ld_addr] at the edge, at any state.
- Load/response collision: a load write and the response read to the same index on the same edge give read-before-write. m_dout returns the old word.
- m_dout is unchanged in cycles without m_ready.

Optional Feature:
IMEM_JITTER_EN
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) advances once per IDLE→WAIT accept. The loaded cnt is LATENCY-1+lfsr[1:0], adding 0..3 extra waits. A restart from an address change reuses the current jitter value.
- Undefined: no LFSR logic; latency is fixed at LATENCY.

Decomposition:
- Package imem_pkg:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - LFSR tap mask constant
  - MAX_LATENCY=15
  - counter width of 6 bits, covering 15+3
- One sub-module, imem_wait_timer: load/decrement counter plus optional LFSR. Ports: load, dec, zero flag.

Test Plan:
1. LATENCY=2, array[5]=32'hDEAD_BEEF via load port; m_strobe=1, m_a=33'h14 at edge 0 -> m_ready high exactly one cycle after edge 2, m_dout=32'hDEAD_BEEF, bus_err=0, busy high during WAIT and RESP.
2. Strobe dropped in WAIT after 1 edge -> no m_ready; state returns to IDLE; the next request is served with full latency.
3. Address change in WAIT, m_a 0x14→0x20 with array[8]=32'h1234_5678 -> counter restarts, m_ready at LATENCY+1 edges after the change, m_dout=32'h1234_5678.
4. m_a=33'h1_0000_0000 (bit 32 set) -> m_ready with bus_err=1, m_dout=0.
5. Load write to index 5 (32'hCAFE_0001) on the response edge of a read of index 5 -> m_dout=old 32'hDEAD_BEEF; an immediate re-request returns 32'hCAFE_0001.
6. clrn pulsed low mid-WAIT -> outputs 0 immediately, no m_ready; array contents preserved on the next read.
